// File: rtl/calc_mean_pkg.sv
// Shared types and constants for the averager scheduler.
package calc_mean_pkg;

    localparam int DATA_W      = 16;
    localparam int AVG_LATENCY = 3;
    localparam int ID_MAX_W    = 3;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Sized for the largest supported requester count; narrower ids zero-extend.
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first valid requester at or after ptr.
module rr_arbiter
    import calc_mean_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      sel,
    output logic [IW-1:0]      next_ptr,
    output logic               accept
);

    logic found_s;
    int   idx_s;

    // Scan requesters starting from the pointer and build the grant
    always_comb begin
        found_s = 1'b0;
        idx_s   = 0;
        sel     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = (int'(ptr) + k) % NUM_REQ;
            if (!found_s && req[IW'(idx_s)]) begin
                found_s = 1'b1;
                sel     = IW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
        accept   = found_s & enable;
        grant    = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel) : {NUM_REQ{1'b0}};
        next_ptr = (int'(sel) == NUM_REQ - 1) ? {IW{1'b0}} : sel + {{(IW-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/calc_mean_sched.sv
// Round-robin issue scheduler for the shared pipelined averager with id return.
// Optional protocol checker: define CALC_MEAN_SCHED_CHECK_EN.
module calc_mean_sched
    import calc_mean_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int LATENCY = AVG_LATENCY,
    localparam int IW      = id_w(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_sign,
    output logic                      avg_enable,
    output logic [DATA_W-1:0]         avg_a,
    output logic [DATA_W-1:0]         avg_b,
    output logic                      avg_sign,
    output logic                      avg_in_strobe,
    input  logic [DATA_W-1:0]         avg_c,
    input  logic                      avg_out_strobe,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [IW-1:0]             rsp_id,
    output logic                      busy,
    output logic                      err
);

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] issue_id_r;
    logic [IW-1:0] sel_s;
    logic [IW-1:0] next_ptr_s;
    logic          accept_s;
    tag_t          tag_r [LATENCY];
    tag_t          tail_s;
    logic          busy_s;
    logic          unused_tag;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req_valid),
        .ptr      (ptr_r),
        .enable   (enable),
        .grant    (req_ready),
        .sel      (sel_s),
        .next_ptr (next_ptr_s),
        .accept   (accept_s)
    );

    assign avg_enable = enable;
    assign tail_s     = tag_r[LATENCY-1];
    assign unused_tag = ^tail_s.id;

    // Issue register, pointer advance and tag pipe; everything freezes with enable low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_r         <= {IW{1'b0}};
            issue_id_r    <= {IW{1'b0}};
            avg_a         <= {DATA_W{1'b0}};
            avg_b         <= {DATA_W{1'b0}};
            avg_sign      <= 1'b0;
            avg_in_strobe <= 1'b0;
            for (int k = 0; k < LATENCY; k++) tag_r[k] <= '0;
        end else if (enable) begin
            avg_in_strobe <= accept_s;
            if (accept_s) begin
                ptr_r      <= next_ptr_s;
                issue_id_r <= sel_s;
                avg_a      <= req_a[int'(sel_s)*DATA_W +: DATA_W];
                avg_b      <= req_b[int'(sel_s)*DATA_W +: DATA_W];
                avg_sign   <= req_sign[sel_s];
            end
            tag_r[0] <= '{valid: avg_in_strobe, id: ID_MAX_W'(issue_id_r)};
            for (int k = 1; k < LATENCY; k++) tag_r[k] <= tag_r[k-1];
        end
    end

    // Response register: a stalled cycle clears the pulse so it is never repeated
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= {NUM_REQ{1'b0}};
            rsp_data  <= {DATA_W{1'b0}};
            rsp_id    <= {IW{1'b0}};
        end else if (enable && tail_s.valid) begin
            rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tail_s.id;
            rsp_data  <= avg_c;
            rsp_id    <= IW'(tail_s.id);
        end else begin
            rsp_valid <= {NUM_REQ{1'b0}};
        end
    end

    // In-flight indication from the issue strobe and tag pipe
    always_comb begin
        busy_s = avg_in_strobe;
        for (int k = 0; k < LATENCY; k++) begin
            busy_s = busy_s | tag_r[k].valid;
        end
    end
    assign busy = busy_s;

`ifdef CALC_MEAN_SCHED_CHECK_EN
    logic err_r;

    // Sticky flag when the averager strobe disagrees with the expected tail slot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (enable && (avg_out_strobe != tail_s.valid)) begin
            err_r <= 1'b1;
        end
    end
    assign err = err_r;
`else
    logic unused_strobe;
    assign unused_strobe = avg_out_strobe;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_calc_mean_sched.sv
// Directed bench for calc_mean_sched with a behavioural 3-cycle averager attached.
module tb_calc_mean_sched;
    import calc_mean_pkg::*;

    localparam int N = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_sign = '0;
    logic [N*16-1:0]   req_a = '0;
    logic [N*16-1:0]   req_b = '0;
    logic [N-1:0]      req_ready;
    logic              avg_enable;
    logic [15:0]       avg_a, avg_b, avg_c;
    logic              avg_sign, avg_in_strobe, avg_out_strobe;
    logic [N-1:0]      rsp_valid;
    logic [15:0]       rsp_data;
    logic [1:0]        rsp_id;
    logic              busy, err;
    logic              inject = 1'b0;
    logic [16:0]       mpipe [3];

    int total = 0;
    int bad   = 0;

    calc_mean_sched #(.NUM_REQ(N), .LATENCY(3)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sign(req_sign),
        .avg_enable(avg_enable), .avg_a(avg_a), .avg_b(avg_b),
        .avg_sign(avg_sign), .avg_in_strobe(avg_in_strobe),
        .avg_c(avg_c), .avg_out_strobe(avg_out_strobe),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] avg_f(input logic signed [15:0] a, input logic signed [15:0] b,
                                          input logic s);
        logic signed [15:0] r;
        r = (a >>> 1) + (b >>> 1);
        return s ? -r : r;
    endfunction

    // Behavioural averager sharing reset and enable with the scheduler
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) mpipe[k] <= '0;
        end else if (avg_enable) begin
            mpipe[0] <= {avg_in_strobe, avg_f(avg_a, avg_b, avg_sign)};
            mpipe[1] <= mpipe[0];
            mpipe[2] <= mpipe[1];
        end
    end
    assign avg_c          = mpipe[2][15:0];
    assign avg_out_strobe = mpipe[2][16] | inject;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_sign[i]       = s;
    endtask

    logic [15:0] e_err;

    initial begin
        #2;
        check_val("rst_strobe", 16'(avg_in_strobe), 16'd0);
        check_val("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check_val("rst_busy", 16'(busy), 16'd0);
        check_val("rst_err", 16'(err), 16'd0);
        check_val("rst_avg_a", avg_a, 16'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // single request from requester 2
        set_req(2, 16'd100, -16'sd40, 1'b0);
        req_valid = 4'b0100;
        #1 check_val("t1_ready", 16'(req_ready), 16'h0004);
        tick();
        req_valid = 4'b0000;
        #1 check_val("t1_ready_off", 16'(req_ready), 16'h0000);
        check_val("t1_in_strobe", 16'(avg_in_strobe), 16'd1);
        check_val("t1_avg_a", avg_a, 16'd100);
        check_val("t1_avg_b", avg_b, 16'hFFD8);
        repeat (3) tick();
        check_val("t1_early", 16'(rsp_valid), 16'h0000);
        tick();
        check_val("t1_rsp_valid", 16'(rsp_valid), 16'h0004);
        check_val("t1_rsp_data", rsp_data, 16'd30);
        check_val("t1_rsp_id", 16'(rsp_id), 16'd2);
        tick();
        check_val("t1_pulse_end", 16'(rsp_valid), 16'h0000);

        // sign path from requester 0 (pointer sits at 3, wraps to 0)
        set_req(0, 16'd200, 16'd100, 1'b1);
        req_valid = 4'b0001;
        #1 check_val("t2_ready", 16'(req_ready), 16'h0001);
        tick();
        req_valid = 4'b0000;
        repeat (4) tick();
        check_val("t2_rsp_valid", 16'(rsp_valid), 16'h0001);
        check_val("t2_rsp_data", rsp_data, -16'sd150);
        check_val("t2_rsp_id", 16'(rsp_id), 16'd0);

        // idle reset to bring the pointer back to 0
        reset = 1'b0;
        #1 check_val("r1_rsp_data", rsp_data, 16'd0);
        tick();
        reset = 1'b1;
        tick();

        // fairness: all four requesters valid for 8 cycles
        for (int i = 0; i < N; i++) set_req(i, 16'((i + 1) * 20), 16'((i + 1) * 4), 1'b0);
        for (int c = 0; c < 13; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) check_val("fair_grant", 16'(req_ready), 16'(1 << (c % 4)));
            if (c >= 5) begin
                check_val("fair_rsp_valid", 16'(rsp_valid), 16'(1 << ((c - 5) % 4)));
                check_val("fair_rsp_data", rsp_data, 16'(12 * (((c - 5) % 4) + 1)));
                check_val("fair_rsp_id", 16'(rsp_id), 16'((c - 5) % 4));
            end
            tick();
        end
        check_val("fair_drain", 16'(rsp_valid), 16'h0000);

        // enable stall right after an acceptance by requester 1
        set_req(1, -16'sd8, 16'd6, 1'b0);
        req_valid = 4'b0010;
        #1 check_val("st_ready", 16'(req_ready), 16'h0002);
        tick();
        enable    = 1'b0;
        req_valid = 4'b1000;
        #1 check_val("st_ready_off1", 16'(req_ready), 16'h0000);
        check_val("st_strobe1", 16'(avg_in_strobe), 16'd1);
        check_val("st_busy", 16'(busy), 16'd1);
        tick();
        #1 check_val("st_ready_off2", 16'(req_ready), 16'h0000);
        check_val("st_strobe2", 16'(avg_in_strobe), 16'd1);
        tick();
        enable    = 1'b1;
        req_valid = 4'b0000;
        repeat (2) tick();
        check_val("st_t5", 16'(rsp_valid), 16'h0000);
        tick();
        check_val("st_t6", 16'(rsp_valid), 16'h0000);
        tick();
        check_val("st_rsp_valid", 16'(rsp_valid), 16'h0002);
        check_val("st_rsp_data", rsp_data, 16'hFFFF);
        check_val("st_rsp_id", 16'(rsp_id), 16'd1);

        // reset with three issues outstanding (pointer now at 2)
        tick();
        req_valid = 4'b1111;
        #1 check_val("mr_grant0", 16'(req_ready), 16'h0004);
        tick();
        #1 check_val("mr_grant1", 16'(req_ready), 16'h0008);
        tick();
        #1 check_val("mr_grant2", 16'(req_ready), 16'h0001);
        tick();
        req_valid = 4'b0000;
        check_val("mr_busy", 16'(busy), 16'd1);
        reset = 1'b0;
        #1 check_val("mr_strobe", 16'(avg_in_strobe), 16'd0);
        check_val("mr_busy_rst", 16'(busy), 16'd0);
        check_val("mr_rsp_data", rsp_data, 16'd0);
        check_val("mr_avg_a", avg_a, 16'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_val("mr_no_rsp", 16'(rsp_valid), 16'h0000);
        end

        // spurious averager strobe with empty tag pipe
`ifdef CALC_MEAN_SCHED_CHECK_EN
        e_err = 16'd1;
`else
        e_err = 16'd0;
`endif
        check_val("err_pre", 16'(err), 16'd0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check_val("err_set", 16'(err), e_err);
        check_val("err_no_rsp", 16'(rsp_valid), 16'h0000);
        repeat (3) tick();
        check_val("err_sticky", 16'(err), e_err);
        reset = 1'b0;
        #1 check_val("err_clear", 16'(err), 16'd0);
        tick();
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
